// File: rtl/timer_sched_cpu.sv
// rtl/timer_sched_cpu.sv - multi-channel timer scheduler sharing one prescaler and one decrementer
// Ports: clk_i clock; reset_i asynchronous active-high reset;
//        address_i/data_i/rd_wr_i register bus (rd_wr_i=1 write, 0 read, every cycle);
//        data_o registered read data; irq_o registered interrupt |((pending[|overrun]) & irq_en).
// Registers at BaseAddress + k*Address_Wording: 0 LOAD, 1 SEL, 2 CTRL, 3 STATUS, 4 ACTIVE, 5 IRQEN,
//        6 OVERRUN when TIMER_SCHED_OVERRUN_EN is defined (reads 0 otherwise).
module timer_sched_cpu #(
    parameter int BaseAddress     = 0,
    parameter int FPGAClkSpeed    = 0,
    parameter int TimerClkSpeed   = 0,
    parameter int address_width   = 16,
    parameter int data_width      = 8,
    parameter int Address_Wording = 1,
    parameter int NumChannels     = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    output logic [data_width-1:0]    data_o,
    input  logic                     rd_wr_i,
    output logic                     irq_o
);

    // A zero clock rate would divide by zero; fall back to the smallest divider
    // that still lets a full scan finish between ticks.
    localparam int TimerDiv = (TimerClkSpeed > 0) ? TimerClkSpeed : 1;
    localparam int RawDiv   = FPGAClkSpeed / TimerDiv;
    localparam int Divider  = (RawDiv >= NumChannels + 2) ? RawDiv : NumChannels + 2;

    localparam logic [31:0] PreLast = 32'(Divider - 1);
    localparam logic [2:0]  LastIdx = 3'(NumChannels - 1);

    localparam logic [address_width-1:0] AddrLoad   = address_width'(BaseAddress);
    localparam logic [address_width-1:0] AddrSel    = address_width'(BaseAddress + 1 * Address_Wording);
    localparam logic [address_width-1:0] AddrCtrl   = address_width'(BaseAddress + 2 * Address_Wording);
    localparam logic [address_width-1:0] AddrStatus = address_width'(BaseAddress + 3 * Address_Wording);
    localparam logic [address_width-1:0] AddrActive = address_width'(BaseAddress + 4 * Address_Wording);
    localparam logic [address_width-1:0] AddrIrqEn  = address_width'(BaseAddress + 5 * Address_Wording);
`ifdef TIMER_SCHED_OVERRUN_EN
    localparam logic [address_width-1:0] AddrOverrun = address_width'(BaseAddress + 6 * Address_Wording);
`endif

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t                 state;
    logic [2:0]             idx;
    logic                   tick_pend;
    logic                   tick;
    logic [31:0]            pre_cnt;
    logic [31:0]            staging;
    logic [2:0]             sel;

    logic [31:0]            reload [NumChannels];
    logic [31:0]            count  [NumChannels];
    logic [NumChannels-1:0] active;
    logic [NumChannels-1:0] periodic;
    logic [NumChannels-1:0] pending;
    logic [NumChannels-1:0] irq_en;

    logic [NumChannels-1:0] svc;
    logic [NumChannels-1:0] cpu_start;
    logic [NumChannels-1:0] cpu_stop;
    logic [NumChannels-1:0] expire;
    logic [NumChannels-1:0] decr;
    logic [NumChannels-1:0] status_clr;
    logic [NumChannels-1:0] pending_nxt;
    logic [NumChannels-1:0] irq_src;
    logic [7:0]             rd_data;

    logic wr_load;
    logic wr_sel;
    logic wr_ctrl;
    logic wr_irqen;
    logic rd_status;

`ifdef TIMER_SCHED_OVERRUN_EN
    logic [NumChannels-1:0] overrun;
    logic [NumChannels-1:0] overrun_clr;
    logic [NumChannels-1:0] overrun_nxt;
    logic                   rd_overrun;
`endif

    assign tick      = (pre_cnt == PreLast);
    assign wr_load   = rd_wr_i && (address_i == AddrLoad);
    assign wr_sel    = rd_wr_i && (address_i == AddrSel);
    assign wr_ctrl   = rd_wr_i && (address_i == AddrCtrl);
    assign wr_irqen  = rd_wr_i && (address_i == AddrIrqEn);
    assign rd_status = !rd_wr_i && (address_i == AddrStatus);

    // Per-channel events for this cycle. A CPU start on the channel being
    // scanned suppresses that channel's decrement/expiry; a stop does not.
    always_comb begin
        svc       = '0;
        cpu_start = '0;
        cpu_stop  = '0;
        expire    = '0;
        decr      = '0;
        for (int i = 0; i < NumChannels; i++) begin
            svc[i]       = (state == ST_SCAN) && (idx == 3'(i));
            cpu_stop[i]  = wr_ctrl && (sel == 3'(i)) && data_i[2];
            cpu_start[i] = wr_ctrl && (sel == 3'(i)) && data_i[0] && !data_i[2];
            expire[i]    = svc[i] && active[i] && !cpu_start[i] && (count[i] == 32'd0);
            decr[i]      = svc[i] && active[i] && !cpu_start[i] && (count[i] != 32'd0);
        end
    end

    // A STATUS read clears only the bits it returns; a simultaneous expiry wins.
    assign status_clr  = rd_status ? pending : '0;
    assign pending_nxt = (pending & ~status_clr) | expire;

`ifdef TIMER_SCHED_OVERRUN_EN
    assign rd_overrun  = !rd_wr_i && (address_i == AddrOverrun);
    assign overrun_clr = rd_overrun ? overrun : '0;
    assign overrun_nxt = (overrun & ~overrun_clr) | (expire & pending);
    assign irq_src     = pending | overrun;
`else
    assign irq_src     = pending;
`endif

    always_comb begin
        rd_data = 8'h00;
        if (address_i == AddrSel) begin
            rd_data = {5'b00000, sel};
        end else if (address_i == AddrStatus) begin
            rd_data = 8'(pending);
        end else if (address_i == AddrActive) begin
            rd_data = 8'(active);
        end else if (address_i == AddrIrqEn) begin
            rd_data = 8'(irq_en);
`ifdef TIMER_SCHED_OVERRUN_EN
        end else if (address_i == AddrOverrun) begin
            rd_data = 8'(overrun);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o    <= '0;
            irq_o     <= 1'b0;
            staging   <= '0;
            sel       <= '0;
            irq_en    <= '0;
            pre_cnt   <= '0;
            state     <= ST_IDLE;
            idx       <= '0;
            tick_pend <= 1'b0;
            active    <= '0;
            periodic  <= '0;
            pending   <= '0;
`ifdef TIMER_SCHED_OVERRUN_EN
            overrun   <= '0;
`endif
            for (int i = 0; i < NumChannels; i++) begin
                reload[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            if (!rd_wr_i) begin
                data_o <= data_width'(rd_data);
            end
            irq_o <= |(irq_src & irq_en);

            if (wr_load) begin
                staging <= {staging[23:0], data_i[7:0]};
            end
            if (wr_sel) begin
                sel <= data_i[2:0];
            end
            if (wr_irqen) begin
                irq_en <= data_i[NumChannels-1:0];
            end

            pre_cnt <= tick ? 32'd0 : pre_cnt + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (tick || tick_pend) begin
                        state     <= ST_SCAN;
                        idx       <= 3'd0;
                        tick_pend <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    // A tick landing mid-scan is remembered, not dropped.
                    if (tick) begin
                        tick_pend <= 1'b1;
                    end
                    if (idx == LastIdx) begin
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            pending <= pending_nxt;
`ifdef TIMER_SCHED_OVERRUN_EN
            overrun <= overrun_nxt;
`endif

            for (int i = 0; i < NumChannels; i++) begin
                if (cpu_start[i]) begin
                    reload[i]   <= staging;
                    count[i]    <= staging;
                    active[i]   <= 1'b1;
                    periodic[i] <= data_i[1];
                end else begin
                    if (decr[i]) begin
                        count[i] <= count[i] - 32'd1;
                    end
                    if (expire[i]) begin
                        if (periodic[i]) begin
                            count[i] <= reload[i];
                        end else begin
                            active[i] <= 1'b0;
                        end
                    end
                    if (cpu_stop[i]) begin
                        active[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
